digit_demux_1x4: RTL and testbench

- Registered 1-to-4 demultiplexer that distributes a single 4-bit digit stream into four held digit registers.
- Feeds the FND display path: upstream logic writes one digit at a time, and this block holds all four for the display scanner.
- Digit slot is chosen either by an explicit select or by an internal auto-incrementing write pointer.
- Emits a one-cycle frame-done pulse when a full 4-digit frame has been written in auto mode.

---
 rtl/fnd_pkg.sv | 14 +
 rtl/digit_demux_1x4_wrap_counter.sv | 46 ++++
 rtl/digit_demux_1x4.sv | 82 ++++++++
 tb/tb_digit_demux_1x4.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared definitions for the FND display path (digit demux and scanner).
//   DATA_W : width of one displayed digit (BCD/hex nibble)
//   N_DIG  : number of digit slots on the display
//   PTR_W  : width of a digit slot index
package fnd_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned N_DIG  = 4;
    localparam int unsigned PTR_W  = 2;

    typedef logic [DATA_W-1:0] digit_t;
    typedef logic [PTR_W-1:0]  ptr_t;

endpackage

// File: rtl/digit_demux_1x4_wrap_counter.sv
// wrap_counter: free-wrapping up counter with enable and synchronous clear.
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset
//   i_clear : synchronous clear (same effect as reset)
//   i_en    : advance the count by one this cycle
//   o_count : current count
//   o_wrap  : one-cycle pulse on the cycle after an enabled step from all-ones
module wrap_counter
    import fnd_pkg::*;
#(
    parameter int unsigned W = PTR_W
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clear,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_wrap
);

    logic [W-1:0] count_q, count_d;
    logic         wrap_q, wrap_d;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (i_en) begin
            count_d = count_q + 1'b1;
            wrap_d  = (count_q == '1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_count = count_q;
    assign o_wrap  = wrap_q;

endmodule

// File: rtl/digit_demux_1x4.sv
// digit_demux_1x4: registered 1-to-4 demultiplexer holding four display digits.
//   i_clk        : clock, rising edge
//   i_reset      : synchronous active-high reset
//   i_data       : digit value to write
//   i_valid      : write strobe
//   i_sel        : target slot in manual mode
//   i_auto       : 1 = target is internal pointer, 0 = target is i_sel
//   i_clear      : synchronous clear of all slots and the pointer
//   o_digits     : held digits, slot k at [k*DATA_W +: DATA_W]
//   o_wr_strobe  : one-hot of the slot written last cycle
//   o_ptr        : current auto write pointer
//   o_frame_done : one-cycle pulse after slot 3 is written in auto mode
module digit_demux_1x4
    import fnd_pkg::*;
#(
    parameter int unsigned DATA_W = fnd_pkg::DATA_W,
    parameter int unsigned N_DIG  = fnd_pkg::N_DIG
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [DATA_W-1:0]       i_data,
    input  logic                    i_valid,
    input  logic [1:0]              i_sel,
    input  logic                    i_auto,
    input  logic                    i_clear,
    output logic [N_DIG*DATA_W-1:0] o_digits,
    output logic [N_DIG-1:0]        o_wr_strobe,
    output logic [1:0]              o_ptr,
    output logic                    o_frame_done
);

    logic [N_DIG-1:0][DATA_W-1:0] digits_q, digits_d;
    logic [N_DIG-1:0]             strobe_q, strobe_d;
    ptr_t                         ptr;
    ptr_t                         target;
    logic                         ptr_en;

    // Pointer only advances on accepted auto-mode writes; clear/reset are
    // handled inside the counter, so a write dropped by clear never counts.
    assign ptr_en = i_valid && i_auto;

    wrap_counter #(
        .W (PTR_W)
    ) u_ptr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (i_clear),
        .i_en    (ptr_en),
        .o_count (ptr),
        .o_wrap  (o_frame_done)
    );

    assign target = i_auto ? ptr : ptr_t'(i_sel);

    always_comb begin
        digits_d = digits_q;
        strobe_d = '0;
        if (i_valid) begin
            for (int unsigned k = 0; k < N_DIG; k++) begin
                if (target == ptr_t'(k)) begin
                    digits_d[k] = i_data;
                    strobe_d[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            digits_q <= '0;
            strobe_q <= '0;
        end else begin
            digits_q <= digits_d;
            strobe_q <= strobe_d;
        end
    end

    assign o_digits    = digits_q;
    assign o_wr_strobe = strobe_q;
    assign o_ptr       = ptr;

endmodule

// File: tb/tb_digit_demux_1x4.sv
module tb_digit_demux_1x4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  data;
    logic        valid;
    logic [1:0]  sel;
    logic        auto_m;
    logic        clr;
    logic [15:0] digits;
    logic [3:0]  wr_strobe;
    logic [1:0]  ptr;
    logic        frame_done;

    digit_demux_1x4 dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_data       (data),
        .i_valid      (valid),
        .i_sel        (sel),
        .i_auto       (auto_m),
        .i_clear      (clr),
        .o_digits     (digits),
        .o_wr_strobe  (wr_strobe),
        .o_ptr        (ptr),
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: four slots, a pointer, last written slot, frame flag.
    int m_slot [4];
    int m_ptr;
    int m_last;   // slot written last cycle, -1 when none
    int m_fd;
    bit check_en = 1'b0;

    always @(posedge clk) begin
        if (rst || clr) begin
            for (int k = 0; k < 4; k++) m_slot[k] = 0;
            m_ptr  = 0;
            m_last = -1;
            m_fd   = 0;
        end else begin
            m_last = -1;
            m_fd   = 0;
            if (valid) begin
                int t;
                t = auto_m ? m_ptr : int'(sel);
                m_slot[t] = int'(data);
                m_last    = t;
                if (auto_m) begin
                    m_fd  = (t == 3) ? 1 : 0;
                    m_ptr = (m_ptr + 1) % 4;
                end
            end
        end
    end

    // Literal expectations posted by the stimulus process.
    bit          lit_pending = 1'b0;
    logic [15:0] lit_digits;
    logic [3:0]  lit_strobe;
    logic [1:0]  lit_ptr;
    logic        lit_fd;
    string       lit_name;

    always @(negedge clk) begin
        if (check_en) begin
            logic [15:0] e_dig;
            logic [3:0]  e_str;
            e_dig = '0;
            for (int k = 0; k < 4; k++) e_dig = e_dig | (16'(m_slot[k]) << (4 * k));
            e_str = (m_last < 0) ? 4'b0000 : 4'(1 << m_last);

            n_checks++;
            if (digits !== e_dig) begin
                n_errors++;
                $display("FAIL digits t=%0t got=%h exp=%h", $time, digits, e_dig);
            end
            n_checks++;
            if (wr_strobe !== e_str) begin
                n_errors++;
                $display("FAIL wr_strobe t=%0t got=%b exp=%b", $time, wr_strobe, e_str);
            end
            n_checks++;
            if (ptr !== 2'(m_ptr)) begin
                n_errors++;
                $display("FAIL ptr t=%0t got=%0d exp=%0d", $time, ptr, m_ptr);
            end
            n_checks++;
            if (frame_done !== 1'(m_fd)) begin
                n_errors++;
                $display("FAIL frame_done t=%0t got=%b exp=%0d", $time, frame_done, m_fd);
            end

            if (lit_pending) begin
                n_checks++;
                if (digits !== lit_digits || wr_strobe !== lit_strobe ||
                    ptr !== lit_ptr || frame_done !== lit_fd) begin
                    n_errors++;
                    $display("FAIL %s got dig=%h str=%b ptr=%0d fd=%b exp dig=%h str=%b ptr=%0d fd=%b",
                             lit_name, digits, wr_strobe, ptr, frame_done,
                             lit_digits, lit_strobe, lit_ptr, lit_fd);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic c, input logic v,
                         input logic a, input logic [1:0] s, input logic [3:0] d);
        @(posedge clk);
        #1;
        rst = r; clr = c; valid = v; auto_m = a; sel = s; data = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
    endtask

    task automatic wr_auto(input logic [3:0] d);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 2'($urandom_range(0, 3)), d);
    endtask

    task automatic wr_man(input logic [1:0] s, input logic [3:0] d);
        drive(1'b0, 1'b0, 1'b1, 1'b0, s, d);
    endtask

    // Outputs currently settling from the previous edge are compared at the
    // coming negedge against these literals.
    task automatic expect_lit(input string name, input logic [15:0] dg, input logic [3:0] st,
                              input logic [1:0] p, input logic fd);
        lit_name = name; lit_digits = dg; lit_strobe = st; lit_ptr = p; lit_fd = fd;
        lit_pending = 1'b1;
        @(negedge clk);
        #1;
        lit_pending = 1'b0;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
        idle();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; valid = 1'b0; auto_m = 1'b0; sel = '0; data = '0;

        // Reset with random other inputs for 3 cycles.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
                  2'($urandom), 4'($urandom));
        check_en = 1'b1;
        idle();
        expect_lit("reset", 16'h0000, 4'b0000, 2'd0, 1'b0);

        // Auto frame 1,2,3,4.
        wr_auto(4'h1);
        wr_auto(4'h2);
        expect_lit("auto_ptr1", 16'h0001, 4'b0001, 2'd1, 1'b0);
        wr_auto(4'h3);
        wr_auto(4'h4);
        expect_lit("auto_ptr3", 16'h0321, 4'b0100, 2'd3, 1'b0);
        idle();
        expect_lit("auto_frame", 16'h4321, 4'b1000, 2'd0, 1'b1);
        idle();
        expect_lit("auto_frame_end", 16'h4321, 4'b0000, 2'd0, 1'b0);

        // Manual select.
        do_reset();
        wr_man(2'd2, 4'h9);
        wr_man(2'd0, 4'h5);
        expect_lit("man_sel2", 16'h0900, 4'b0100, 2'd0, 1'b0);
        idle();
        expect_lit("man_sel0", 16'h0905, 4'b0001, 2'd0, 1'b0);

        // Clear beats a simultaneous write.
        wr_auto(4'hF);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 4'h7);
        idle();
        expect_lit("clear_vs_write", 16'h0000, 4'b0000, 2'd0, 1'b0);

        // Mode switch mid-frame: A,B auto; C manual to slot 3; D,E auto.
        do_reset();
        wr_auto(4'hA);
        wr_auto(4'hB);
        wr_man(2'd3, 4'hC);
        expect_lit("switch_frozen", 16'h00BA, 4'b0010, 2'd2, 1'b0);
        wr_auto(4'hD);
        wr_auto(4'hE);
        expect_lit("switch_D", 16'hCDBA, 4'b0100, 2'd3, 1'b0);
        idle();
        expect_lit("switch_E", 16'hEDBA, 4'b1000, 2'd0, 1'b1);

        // Reset mid-frame with a simultaneous write.
        wr_auto(4'h6);
        wr_auto(4'h7);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 4'h8);
        idle();
        expect_lit("reset_mid_frame", 16'h0000, 4'b0000, 2'd0, 1'b0);
        wr_auto(4'hB);
        idle();
        expect_lit("after_reset_slot0", 16'h000B, 4'b0001, 2'd1, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 3),
                  1'($urandom_range(0, 99) < 75), 1'($urandom_range(0, 99) < 70),
                  2'($urandom), 4'($urandom));
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
